retire_buffer: RTL
==================

RETIRE_BUFFER -- requirements
Module: retire_buffer

Interface
REQ-001 SHALL have parameter embedded, default 1: register address width raddr_w = 4 when 1, else 5.
REQ-002 SHALL have parameter wb_depth, default 16: power of two ≥ 2; number of slots; tag width wb_tag_w = clog2(wb_depth).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port IssueValid  input  1  pulse per tag allocation (destination register ≠ x0).
REQ-006 SHALL have port IssueFull  output  1  outstanding tags = wb_depth; dispatch stalls.
REQ-007 SHALL have port CplValid  input  1  execution result valid.
REQ-008 SHALL have port CplTag  input  wb_tag_w  tag of result.
REQ-009 SHALL have port CplAddr  input  raddr_w  destination register.
REQ-010 SHALL have port CplData  input  32  result value.
REQ-011 SHALL have port WbAddr  output  raddr_w  regfile write address; 0 = no write.
REQ-012 SHALL have port WbTag  output  wb_tag_w  tag being retired.
REQ-013 SHALL have port RdData  output  32  retired value.
REQ-014 SHALL have ports Rs1Tag / Rs2Tag  input  wb_tag_w  hot-operand tags from the regfile.
REQ-015 SHALL have ports Rs1Fwd / Rs2Fwd  output  32  forwarded data.
REQ-016 SHALL have ports Rs1FwdValid / Rs2FwdValid  output  1  tag slot holds completed data.
REQ-017 SHALL have port CplErr  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL store each completion in the slot indexed by CplTag (address, data, valid bit), written at the rising edge where CplValid=1.
REQ-019 SHALL keep head pointer HeadTag; retire in strict tag order, at most one retirement per cycle.
REQ-020 SHALL drive WbAddr/WbTag/RdData combinationally from the head slot when it is valid, else WbAddr=0, WbTag=HeadTag, RdData=0.
REQ-021 SHALL, at each edge where the head slot is valid, clear that slot and increment HeadTag modulo 2^wb_tag_w; the regfile commit and the slot clear occur on the same edge, so there is no forwarding gap.
REQ-022 Latency: completion at edge N for the head tag -> Wb outputs valid in cycle N+1 -> retired at edge N+1.
REQ-023 SHALL drive RsxFwdValid = valid[Rsx Tag] and RsxFwd = data[Rsx Tag], both combinational; a completion becomes forwardable in the cycle after its edge.
REQ-024 SHALL keep Outstanding counter, width wb_tag_w+1: +1 on IssueValid, -1 on retirement, unchanged when both occur in the same cycle.
REQ-025 SHALL assert IssueFull when Outstanding = wb_depth; IssueValid while full sets CplErr and is not counted.
REQ-026 SHALL set CplErr on any of: completion to an already-valid slot (write ignored); CplAddr=0 (write ignored); completion when Outstanding=0 (write ignored).
REQ-027 SHALL accept a completion to a tag other than the head tag in the same cycle that the head retires.
REQ-028 SHALL wrap HeadTag from 2^wb_tag_w-1 to 0 without a bubble.

Reset
REQ-029 SHALL, while rst=0, asynchronously set HeadTag=1 (the first allocated tag), Outstanding=0, all valid bits=0, CplErr=0.
REQ-030 SHALL, after reset, drive outputs WbAddr=0, WbTag=1, RdData=0, IssueFull=0, FwdValid=0, Fwd=0.
REQ-031 SHALL discard in-flight completions when reset is asserted mid-operation; slot data needs no reset.

Structure
REQ-032 SHALL place raddr_w/wb_tag_w derivation functions and the slot typedef (addr, data) in shared package rv_wb_pkg.
REQ-033 SHALL use one sub-module, retire_slot_file: slot storage plus valid bits, one write port, one clear port, three combinational read ports (head, Rs1, Rs2).

Verification
REQ-034 SHALL cover in-order completion: issue tags 1,2; complete tag1 (x5, 0xA5A5A5A5) -> next cycle WbAddr=5, WbTag=1, RdData=0xA5A5A5A5; HeadTag=2 after the edge.
REQ-035 SHALL cover out-of-order completion: issue 1,2,3; complete 3, then 2, then 1 -> WbAddr stays 0 until tag1 arrives, then tags 1,2,3 retire on three consecutive cycles.
REQ-036 SHALL cover forwarding: complete tag4 (0x1234) while head = 2; Rs1Tag=4 -> Rs1FwdValid=1, Rs1Fwd=0x1234 until tag4 retires, then 0.
REQ-037 SHALL cover full: 16 IssueValid pulses with no completions -> IssueFull=1; one retirement together with an IssueValid -> IssueFull stays 1.
REQ-038 SHALL cover wrap: run 40 tags in order -> HeadTag passes 15 -> 0 -> 1 with one retirement per cycle and no bubble.
REQ-039 SHALL cover errors and reset: duplicate completion to tag2 -> CplErr=1, data unchanged; then rst=0 mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared types and width helpers for the retire buffer.
package rv_wb_pkg;

    localparam int unsigned RaddrMax = 5;
    localparam int unsigned DataW    = 32;

    // Register address width: 16-entry regfile when embedded, else 32.
    function automatic int unsigned raddr_w(input int unsigned embedded);
        return (embedded != 0) ? 4 : 5;
    endfunction

    function automatic int unsigned wb_tag_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Slot payload. The address field is sized for the wider regfile.
    typedef struct packed {
        logic [RaddrMax-1:0] addr;
        logic [DataW-1:0]    data;
    } slot_t;

endpackage

// File: rtl/retire_buffer_if.sv
// Issue/completion/writeback/forwarding bundle between dispatch, execute and regfile.
interface retire_buffer_if #(
    parameter int unsigned embedded = 1,
    parameter int unsigned wb_depth = 16
) ();
    import rv_wb_pkg::*;

    localparam int unsigned RaddrW = raddr_w(embedded);
    localparam int unsigned TagW   = wb_tag_w(wb_depth);

    logic              IssueValid;
    logic              IssueFull;
    logic              CplValid;
    logic [TagW-1:0]   CplTag;
    logic [RaddrW-1:0] CplAddr;
    logic [31:0]       CplData;
    logic [RaddrW-1:0] WbAddr;
    logic [TagW-1:0]   WbTag;
    logic [31:0]       RdData;
    logic [TagW-1:0]   Rs1Tag;
    logic [TagW-1:0]   Rs2Tag;
    logic [31:0]       Rs1Fwd;
    logic [31:0]       Rs2Fwd;
    logic              Rs1FwdValid;
    logic              Rs2FwdValid;
    logic              CplErr;

    modport master (
        output IssueValid, CplValid, CplTag, CplAddr, CplData, Rs1Tag, Rs2Tag,
        input  IssueFull, WbAddr, WbTag, RdData, Rs1Fwd, Rs2Fwd, Rs1FwdValid, Rs2FwdValid,
               CplErr
    );

    modport slave (
        input  IssueValid, CplValid, CplTag, CplAddr, CplData, Rs1Tag, Rs2Tag,
        output IssueFull, WbAddr, WbTag, RdData, Rs1Fwd, Rs2Fwd, Rs1FwdValid, Rs2FwdValid,
               CplErr
    );

endinterface

// File: rtl/retire_slot_file.sv
// Tag-indexed slot storage: one write port, one clear port, three read ports.
module retire_slot_file
    import rv_wb_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned TagW  = wb_tag_w(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [TagW-1:0]  i_wr_tag,
    input  slot_t            i_wr_slot,
    output logic             o_wr_busy,
    input  logic             i_clr_en,
    input  logic [TagW-1:0]  i_clr_tag,
    input  logic [TagW-1:0]  i_head_tag,
    output logic             o_head_valid,
    output slot_t            o_head_slot,
    input  logic [TagW-1:0]  i_rs1_tag,
    output logic             o_rs1_valid,
    output logic [DataW-1:0] o_rs1_data,
    input  logic [TagW-1:0]  i_rs2_tag,
    output logic             o_rs2_valid,
    output logic [DataW-1:0] o_rs2_data
);

    logic [Depth-1:0] r_valid;
    slot_t            r_slot [Depth];

    // Valid bits: cleared on retirement, set on an accepted completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            if (i_clr_en) r_valid[i_clr_tag] <= 1'b0;
            if (i_wr_en)  r_valid[i_wr_tag]  <= 1'b1;
        end
    end

    // Payload storage; unreset because every read is qualified by its valid bit.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_slot[i_wr_tag] <= i_wr_slot;
    end

    // Combinational read ports.
    always_comb begin
        o_wr_busy    = r_valid[i_wr_tag];
        o_head_valid = r_valid[i_head_tag];
        o_head_slot  = r_slot[i_head_tag];
        o_rs1_valid  = r_valid[i_rs1_tag];
        o_rs1_data   = r_slot[i_rs1_tag].data;
        o_rs2_valid  = r_valid[i_rs2_tag];
        o_rs2_data   = r_slot[i_rs2_tag].data;
    end

endmodule

// File: rtl/retire_buffer.sv
// In-order retirement of out-of-order completions, with operand forwarding.
module retire_buffer
    import rv_wb_pkg::*;
#(
    parameter int unsigned embedded = 1,
    parameter int unsigned wb_depth = 16
) (
    input  logic           clk,
    input  logic           rst,
    retire_buffer_if.slave bus
);

    localparam int unsigned     RaddrW  = raddr_w(embedded);
    localparam int unsigned     TagW    = wb_tag_w(wb_depth);
    localparam int unsigned     CntW    = TagW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(wb_depth);

    logic [TagW-1:0]  r_head, w_head_nxt;
    logic [CntW-1:0]  r_outstanding, w_outstanding_nxt;
    logic             r_cpl_err, w_cpl_err_nxt;

    logic             w_head_valid;
    slot_t            w_head_slot;
    logic             w_wr_busy;
    logic             w_rs1_valid, w_rs2_valid;
    logic [DataW-1:0] w_rs1_data, w_rs2_data;
    slot_t            w_wr_slot;
    logic             w_full, w_retire, w_issue_ok, w_issue_err, w_cpl_bad, w_cpl_ok;
    logic             w_unused_addr;

    retire_slot_file #(
        .Depth (wb_depth)
    ) u_slot_file (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (w_cpl_ok),
        .i_wr_tag     (bus.CplTag),
        .i_wr_slot    (w_wr_slot),
        .o_wr_busy    (w_wr_busy),
        .i_clr_en     (w_retire),
        .i_clr_tag    (r_head),
        .i_head_tag   (r_head),
        .o_head_valid (w_head_valid),
        .o_head_slot  (w_head_slot),
        .i_rs1_tag    (bus.Rs1Tag),
        .o_rs1_valid  (w_rs1_valid),
        .o_rs1_data   (w_rs1_data),
        .i_rs2_tag    (bus.Rs2Tag),
        .o_rs2_valid  (w_rs2_valid),
        .o_rs2_data   (w_rs2_data)
    );

    // Accept/reject decisions for this cycle's issue and completion.
    always_comb begin
        w_full      = (r_outstanding == FullCnt);
        w_retire    = w_head_valid;
        // A retirement this cycle frees a tag, so an issue while full is still legal.
        w_issue_ok  = bus.IssueValid && (!w_full || w_retire);
        w_issue_err = bus.IssueValid && !w_issue_ok;
        w_cpl_bad   = bus.CplValid &&
                      (w_wr_busy || (bus.CplAddr == '0) || (r_outstanding == '0));
        w_cpl_ok    = bus.CplValid && !w_cpl_bad;
        w_wr_slot.addr = RaddrMax'(bus.CplAddr);
        w_wr_slot.data = bus.CplData;
    end

    // Next-state for head pointer, outstanding count and sticky error.
    always_comb begin
        w_head_nxt        = r_head;
        w_outstanding_nxt = r_outstanding;
        w_cpl_err_nxt     = r_cpl_err | w_issue_err | w_cpl_bad;
        if (w_retire) w_head_nxt = r_head + TagW'(1);
        case ({w_issue_ok, w_retire})
            2'b10:   w_outstanding_nxt = r_outstanding + CntW'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - CntW'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase
    end

    // State registers; head starts at tag 1, the first tag dispatch allocates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head        <= TagW'(1);
            r_outstanding <= '0;
            r_cpl_err     <= 1'b0;
        end else begin
            r_head        <= w_head_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_cpl_err     <= w_cpl_err_nxt;
        end
    end

    // Upper address bit of the slot is spare on the embedded regfile.
    assign w_unused_addr = ^w_head_slot.addr;

    assign bus.IssueFull   = w_full;
    assign bus.WbAddr      = w_head_valid ? w_head_slot.addr[RaddrW-1:0] : '0;
    assign bus.WbTag       = r_head;
    assign bus.RdData      = w_head_valid ? w_head_slot.data : '0;
    assign bus.Rs1FwdValid = w_rs1_valid;
    assign bus.Rs1Fwd      = w_rs1_valid ? w_rs1_data : '0;
    assign bus.Rs2FwdValid = w_rs2_valid;
    assign bus.Rs2Fwd      = w_rs2_valid ? w_rs2_data : '0;
    assign bus.CplErr      = r_cpl_err;

endmodule
